// File: rtl/fifo2axi_if.sv
// AXI4 bus bundle for fifo2axi: AR/R read channels and AW/W/B write channels.
// slave modport is the fifo2axi side, master modport the bus-master side.
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where valid and ready are both 1; once valid is raised the sender keeps
// valid and its payload unchanged until that edge, and ready may toggle freely.
interface fifo2axi_if #(
    parameter int AW = 6,
    parameter int DW = 128
);
    logic [AW-1:0] araddr;
    logic [15:0]   arid;
    logic [7:0]    arlen;
    logic          arvalid;
    logic          arready;

    logic [DW-1:0] rdata;
    logic [15:0]   rid;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    logic [AW-1:0] awaddr;
    logic [15:0]   awid;
    logic [7:0]    awlen;
    logic          awvalid;
    logic          awready;

    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wlast;
    logic          wready;

    logic [15:0]   bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;

    modport slave (
        input  araddr, arid, arlen, arvalid,
        output arready,
        output rdata, rid, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awid, awlen, awvalid,
        output awready,
        input  wdata, wvalid, wlast,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output araddr, arid, arlen, arvalid,
        input  arready,
        input  rdata, rid, rresp, rlast, rvalid,
        output rready,
        output awaddr, awid, awlen, awvalid,
        input  awready,
        output wdata, wvalid, wlast,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/fifo2axi.sv
// fifo2axi: AXI4 slave draining a first-word-fall-through FIFO onto the R channel.
//   read  0x00 : each R beat pops one FIFO word (empty FIFO -> rdata=0, SLVERR)
//   read  0x10 : status word {pop_count at [63:32], fifo_full, fifo_empty at [1:0]}
//   write 0x10 : any beat with wdata[0]=1 requests a one-cycle fifo_flush pulse
//   other addresses answer SLVERR.
// Optional macro FIFO2AXI_TIMEOUT_EN: an empty-FIFO data beat waits up to
// TIMEOUT_CYCLES for data before returning SLVERR; without it the error beat
// is returned immediately.
// dbg_rd_state / dbg_wr_state expose the two FSM states.
module fifo2axi #(
    parameter int AXI_ADDR_WIDTH = 6,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_areset,
    fifo2axi_if.slave                 s_axi,
    input  logic [AXI_DATA_WIDTH-1:0] fifo_dout,
    input  logic                      fifo_empty,
    input  logic                      fifo_full,
    output logic                      fifo_rd_en,
    output logic                      fifo_flush,
    output logic [1:0]                dbg_rd_state,
    output logic [1:0]                dbg_wr_state
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_DATA = '0;
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STAT = AXI_ADDR_WIDTH'(16);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef FIFO2AXI_TIMEOUT_EN
    localparam int WAIT_LIMIT = TIMEOUT_CYCLES;
`else
    localparam int WAIT_LIMIT = 0;
`endif

    typedef enum logic [1:0] {R_IDLE, R_DATA, R_STAT} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

    rd_state_t rd_state;
    wr_state_t wr_state;

    logic [8:0]                beats_left;
    logic                      stat_err;
    logic [CW-1:0]             wait_cnt;
    logic [31:0]               pop_count;
    logic [15:0]               awid_q;
    logic                      wr_to_stat;
    logic                      flush_flag;

    logic                      load_slot;
    logic                      beat_due;
    logic                      data_beat;
    logic                      wait_done;
    logic                      ld;
    logic [AXI_DATA_WIDTH-1:0] ld_data;
    logic [1:0]                ld_resp;
    logic [AXI_DATA_WIDTH-1:0] stat_word;
    logic                      w_beat;
    logic                      flush_next;
    logic                      flush_clear;
    logic                      unused_ok;

    assign unused_ok = ^{s_axi.awlen, s_axi.wdata[AXI_DATA_WIDTH-1:1]};

    assign dbg_rd_state  = rd_state;
    assign dbg_wr_state  = wr_state;
    assign s_axi.arready = (rd_state == R_IDLE);
    assign s_axi.awready = (wr_state == W_IDLE);
    assign s_axi.wready  = (wr_state == W_DATA);

    // A new beat may enter the R register when it is empty or being drained
    // this cycle; a pending flush pulse defers the beat by one cycle.
    assign load_slot  = !s_axi.rvalid || s_axi.rready;
    assign beat_due   = (rd_state != R_IDLE) && (beats_left != 9'd0) && load_slot && !fifo_flush;
    assign data_beat  = beat_due && (rd_state == R_DATA);
    assign wait_done  = (wait_cnt == CW'(WAIT_LIMIT));
    assign fifo_rd_en = data_beat && !fifo_empty && !s_axi_areset;

    assign w_beat      = s_axi.wvalid && s_axi.wready;
    assign flush_next  = flush_flag || (wr_to_stat && s_axi.wdata[0]);
    assign flush_clear = w_beat && s_axi.wlast && flush_next;

    // Status word and the beat (if any) that enters the R register this cycle.
    always_comb begin
        stat_word        = '0;
        stat_word[63:32] = pop_count;
        stat_word[1:0]   = {fifo_full, fifo_empty};
        ld      = 1'b0;
        ld_data = '0;
        ld_resp = RESP_OKAY;
        if (beat_due) begin
            if (rd_state == R_STAT) begin
                ld      = 1'b1;
                ld_data = stat_err ? '0 : stat_word;
                ld_resp = stat_err ? RESP_SLVERR : RESP_OKAY;
            end else if (!fifo_empty) begin
                ld      = 1'b1;
                ld_data = fifo_dout;
            end else if (wait_done) begin
                ld      = 1'b1;
                ld_resp = RESP_SLVERR;
            end
        end
    end

    // Read FSM: AR acceptance, beat loading and R channel holding registers.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            rd_state     <= R_IDLE;
            beats_left   <= '0;
            stat_err     <= 1'b0;
            wait_cnt     <= '0;
            s_axi.rvalid <= 1'b0;
            s_axi.rdata  <= '0;
            s_axi.rresp  <= RESP_OKAY;
            s_axi.rlast  <= 1'b0;
            s_axi.rid    <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (s_axi.arvalid) begin
                        s_axi.rid  <= s_axi.arid;
                        beats_left <= {1'b0, s_axi.arlen} + 9'd1;
                        stat_err   <= (s_axi.araddr != ADDR_DATA) && (s_axi.araddr != ADDR_STAT);
                        rd_state   <= (s_axi.araddr == ADDR_DATA) ? R_DATA : R_STAT;
                    end
                end
                default: begin
                    if (s_axi.rvalid && s_axi.rready) begin
                        s_axi.rvalid <= 1'b0;
                        if (s_axi.rlast) rd_state <= R_IDLE;
                    end
                    if (ld) begin
                        s_axi.rvalid <= 1'b1;
                        s_axi.rdata  <= ld_data;
                        s_axi.rresp  <= ld_resp;
                        s_axi.rlast  <= (beats_left == 9'd1);
                        beats_left   <= beats_left - 9'd1;
                        wait_cnt     <= '0;
                    end else if (data_beat && fifo_empty) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end else begin
                        wait_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // Pop counter: cleared by a flush command, otherwise counts every pop, wraps.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset)    pop_count <= '0;
        else if (flush_clear) pop_count <= '0;
        else if (fifo_rd_en)  pop_count <= pop_count + 32'd1;
    end

    // Write FSM: AW acceptance, W beat collection, flush pulse and B response.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            wr_state     <= W_IDLE;
            awid_q       <= '0;
            wr_to_stat   <= 1'b0;
            flush_flag   <= 1'b0;
            fifo_flush   <= 1'b0;
            s_axi.bvalid <= 1'b0;
            s_axi.bid    <= '0;
            s_axi.bresp  <= RESP_OKAY;
        end else begin
            fifo_flush <= 1'b0;
            case (wr_state)
                W_IDLE: begin
                    if (s_axi.awvalid) begin
                        awid_q     <= s_axi.awid;
                        wr_to_stat <= (s_axi.awaddr == ADDR_STAT);
                        flush_flag <= 1'b0;
                        wr_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        flush_flag <= flush_next;
                        if (s_axi.wlast) begin
                            fifo_flush   <= flush_next;
                            s_axi.bvalid <= 1'b1;
                            s_axi.bid    <= awid_q;
                            s_axi.bresp  <= wr_to_stat ? RESP_OKAY : RESP_SLVERR;
                            wr_state     <= W_RESP;
                        end
                    end
                end
                default: begin
                    if (s_axi.bready) begin
                        s_axi.bvalid <= 1'b0;
                        wr_state     <= W_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo2axi.sv
// Bench for fifo2axi: the bench plays the FWFT FIFO and the AXI master, and
// predicts every R/B response from a queue model of the FIFO contents.
module tb_fifo2axi;
    localparam int AW         = 6;
    localparam int DW         = 128;
    localparam int EW         = DW + 2 + 1 + 16;
    localparam int FULL_LEVEL = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo2axi_if #(.AW(AW), .DW(DW)) s_axi ();

    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_rd_en;
    logic          fifo_flush;
    logic [1:0]    dbg_rd_state;
    logic [1:0]    dbg_wr_state;

    fifo2axi #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(256)) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .s_axi        (s_axi),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_flush   (fifo_flush),
        .dbg_rd_state (dbg_rd_state),
        .dbg_wr_state (dbg_wr_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] fq[$];          // physical FIFO contents seen by the DUT
    logic [DW-1:0] mq[$];          // model of what the FIFO should hold
    logic [EW-1:0] exp_q[$];       // expected R beats {rdata, rresp, rlast, rid}
    logic [31:0]   mdl_pops    = 0;
    int            mdl_flushes = 0;
    int            pops_seen    = 0;
    int            flushes_seen = 0;

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void fifo_sync();
        fifo_dout  = (fq.size() > 0) ? fq[0] : '0;
        fifo_empty = (fq.size() == 0);
        fifo_full  = (fq.size() >= FULL_LEVEL);
    endfunction

    // FIFO behaviour: pops/flushes take effect at the edge where they are strobed.
    always @(posedge clk) begin
        logic rd_s;
        logic fl_s;
        rd_s = fifo_rd_en;
        fl_s = fifo_flush;
        if (rd_s) pops_seen++;
        if (fl_s) flushes_seen++;
        #1;
        if (fl_s) fq.delete();
        else if (rd_s && fq.size() > 0) void'(fq.pop_front());
        fifo_sync();
    end

    always @(negedge clk) begin
        if (fifo_rd_en) check("rden_while_empty", EW'(fifo_empty), EW'(0));
    end

    task automatic push(input int n);
        logic [DW-1:0] w;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            fq.push_back(w);
            mq.push_back(w);
        end
        fifo_sync();
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int len, input bit rand_ready);
        logic [15:0]   id;
        logic [DW-1:0] d;
        logic [1:0]    resp;
        logic [EW-1:0] cur;
        logic [EW-1:0] hold_w;
        bit            hold_v;
        int            exp_pop;
        int            pops_before;
        int            t;
        id = 16'($urandom);
        exp_pop = 0;
        pops_before = pops_seen;
        for (int i = 0; i <= len; i++) begin
            d = '0;
            resp = 2'b10;
            if (addr == 6'h00) begin
                if (mq.size() > 0) begin
                    d = mq.pop_front();
                    resp = 2'b00;
                    exp_pop++;
                end
            end else if (addr == 6'h10) begin
                d[63:32] = mdl_pops;
                d[1] = (mq.size() >= FULL_LEVEL);
                d[0] = (mq.size() == 0);
                resp = 2'b00;
            end
            exp_q.push_back({d, resp, (i == len), id});
        end
        mdl_pops += 32'(exp_pop);

        @(posedge clk); #1;
        s_axi.araddr = addr; s_axi.arid = id; s_axi.arlen = 8'(len); s_axi.arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_axi.arready && t < 50) begin @(negedge clk); t++; end
        if (!s_axi.arready) check("ar_timeout", EW'(0), EW'(1));
        @(posedge clk); #1;
        s_axi.arvalid = 1'b0;

        hold_v = 0;
        hold_w = '0;
        t = 0;
        while (exp_q.size() > 0 && t < 3000) begin
            s_axi.rready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (s_axi.rvalid) begin
                cur = {s_axi.rdata, s_axi.rresp, s_axi.rlast, s_axi.rid};
                if (hold_v) check("r_stable", cur, hold_w);
                if (s_axi.rready) begin
                    check("r_beat", cur, exp_q.pop_front());
                    hold_v = 0;
                end else begin
                    hold_v = 1;
                    hold_w = cur;
                end
            end
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() > 0) begin
            check("r_timeout", EW'(exp_q.size()), EW'(0));
            exp_q.delete();
        end
        s_axi.rready = 1'b0;
        check("pop_count", EW'(pops_seen - pops_before), EW'(exp_pop));
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input int nb, input int flush_idx);
        logic [15:0] id;
        logic [DW-1:0] w;
        bit exp_flush;
        int t;
        id = 16'($urandom);
        exp_flush = (addr == 6'h10) && (flush_idx >= 0) && (flush_idx < nb);

        @(posedge clk); #1;
        s_axi.awaddr = addr; s_axi.awid = id; s_axi.awlen = 8'(nb - 1); s_axi.awvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_axi.awready && t < 50) begin @(negedge clk); t++; end
        if (!s_axi.awready) check("aw_timeout", EW'(0), EW'(1));
        @(posedge clk); #1;
        s_axi.awvalid = 1'b0;

        for (int i = 0; i < nb; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            w[0] = (i == flush_idx);
            s_axi.wdata = w; s_axi.wlast = (i == nb - 1); s_axi.wvalid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!s_axi.wready && t < 50) begin @(negedge clk); t++; end
            if (!s_axi.wready) check("w_timeout", EW'(0), EW'(1));
            @(posedge clk); #1;
        end
        s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;

        s_axi.bready = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_axi.bvalid && t < 50) begin @(negedge clk); t++; end
        check("b_resp", EW'({s_axi.bvalid, s_axi.bid, s_axi.bresp}),
              EW'({1'b1, id, (addr == 6'h10) ? 2'b00 : 2'b10}));
        @(posedge clk); #1;
        s_axi.bready = 1'b0;
        if (exp_flush) begin
            mq.delete();
            mdl_pops = 0;
            mdl_flushes++;
        end
        @(negedge clk);
        check("flush_pulses", EW'(flushes_seen), EW'(mdl_flushes));
    endtask

    initial begin
        int pops_before;
        rst = 1'b1;
        s_axi.araddr = '0; s_axi.arid = '0; s_axi.arlen = '0; s_axi.arvalid = 1'b0;
        s_axi.rready = 1'b0;
        s_axi.awaddr = '0; s_axi.awid = '0; s_axi.awlen = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0; s_axi.bready = 1'b0;
        fifo_sync();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_outputs", EW'({s_axi.arready, s_axi.awready, s_axi.wready, s_axi.rvalid,
                                  s_axi.bvalid, fifo_rd_en, fifo_flush}), EW'(7'b1100000));

        // Directed cases
        push(3);                    axi_read(6'h00, 2, 0);      // A,B,C OKAY, rlast on C
        push(1);                    axi_read(6'h00, 1, 0);      // A OKAY then empty SLVERR
        push(4);                    axi_read(6'h00, 3, 1);      // stalled burst
        axi_read(6'h10, 0, 0);                                  // status: pop count, empty
        push(20);                   axi_read(6'h10, 1, 1);      // status with full set
        axi_write(6'h10, 1, 0);                                 // flush
        axi_read(6'h10, 0, 0);                                  // count back to 0, empty
        push(2);                    axi_write(6'h20, 2, 0);     // SLVERR, no flush
        axi_read(6'h08, 1, 0);                                  // SLVERR, no pop
        axi_write(6'h10, 3, -1);                                // no flush bit
        axi_write(6'h10, 3, 2);                                 // flush on last beat

        // Randomized mix
        for (int it = 0; it < 14; it++) begin
            push($urandom_range(0, 6));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: axi_read(6'h00, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
                5, 6:          axi_read(6'h10, $urandom_range(0, 2), 1);
                7:             axi_write(6'h10, $urandom_range(1, 3), $urandom_range(0, 4) - 1);
                8:             axi_write(6'h20, $urandom_range(1, 3), 0);
                default:       axi_read(6'h08, $urandom_range(0, 2), 1);
            endcase
        end

        // Maximum burst length, FIFO runs dry part way through
        axi_write(6'h10, 1, 0);
        push(200);
        axi_read(6'h00, 255, 1);
        axi_read(6'h10, 0, 0);

        // Reset in the middle of a stalled burst
        push(3);
        pops_before = pops_seen;
        @(posedge clk); #1;
        s_axi.araddr = 6'h00; s_axi.arid = 16'h1234; s_axi.arlen = 8'd7; s_axi.arvalid = 1'b1;
        @(posedge clk); #1;
        s_axi.arvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_burst", EW'({s_axi.rvalid, s_axi.bvalid, s_axi.arready, s_axi.awready,
                                    fifo_rd_en}), EW'(5'b00110));
        repeat (4) @(negedge clk);
        check("rst_pops", EW'(pops_seen - pops_before), EW'(1));
        void'(mq.pop_front());
        mdl_pops = 0;
        axi_read(6'h10, 0, 0);                                  // counter cleared by reset
        axi_read(6'h00, 1, 0);                                  // remaining words in order

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
